// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg_scan_ctrl                                                 |
// | Brief    : Multiplexed BCD 7-segment scan controller with frame-aligned  |
// |            commit of written digit values. Define SEG_LZ_BLANK_EN to     |
// |            enable leading-zero blanking.                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [3:0]                    wr_data,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         dig_en,
  output logic                          frame_tick
);

  localparam int c_addr_w = $clog2(NUM_DIGITS);
  localparam int c_cnt_w  = $clog2(PRESCALE);
  localparam logic [c_cnt_w-1:0]    c_cnt_max = c_cnt_w'(PRESCALE - 1);
  localparam logic [c_cnt_w-1:0]    c_blank   = c_cnt_w'(BLANK_CYCLES);
  localparam logic [c_addr_w-1:0]   c_idx_max = c_addr_w'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_one     = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [c_cnt_w-1:0]          r_cnt, w_cnt_nxt;
  logic [c_addr_w-1:0]         r_idx, w_idx_nxt;
  logic [NUM_DIGITS-1:0][3:0]  r_shadow, r_disp;
  logic                        r_dirty;
  logic [6:0]                  r_seg, w_seg;
  logic [NUM_DIGITS-1:0]       r_dig_en;
  logic                        r_frame_tick;
  logic                        w_frame_end, w_commit, w_wr_hit;

  function automatic logic [6:0] f_decode(input logic [3:0] v);
    case (v)
      4'd0:    f_decode = 7'h7E;
      4'd1:    f_decode = 7'h30;
      4'd2:    f_decode = 7'h6D;
      4'd3:    f_decode = 7'h79;
      4'd4:    f_decode = 7'h33;
      4'd5:    f_decode = 7'h5B;
      4'd6:    f_decode = 7'h5F;
      4'd7:    f_decode = 7'h70;
      4'd8:    f_decode = 7'h7F;
      4'd9:    f_decode = 7'h7B;
      default: f_decode = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    if (!ena || r_state == ST_IDLE) begin
      // Scan always (re)starts from digit 0 at the top of a blank slot.
      w_state_nxt = ena ? ST_BLANK : ST_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      if (r_cnt == c_cnt_max) begin
        w_cnt_nxt = '0;
        w_idx_nxt = (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
      w_state_nxt = (w_cnt_nxt < c_blank) ? ST_BLANK : ST_SHOW;
    end
  end

  assign w_frame_end = (r_state != ST_IDLE) && (r_cnt == c_cnt_max) && (r_idx == c_idx_max);
  assign w_commit    = r_dirty && ((r_state == ST_IDLE) || w_frame_end);
  assign wr_ready    = ~w_commit;
  assign w_wr_hit    = wr_valid && wr_ready && (int'(wr_addr) < NUM_DIGITS);

  // Writes land in the shadow bank; the display bank only changes on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '1;
      r_disp   <= '1;
      r_dirty  <= 1'b0;
    end else if (w_commit) begin
      r_disp  <= r_shadow;
      r_dirty <= 1'b0;
    end else if (w_wr_hit) begin
      r_shadow[wr_addr] <= wr_data;
      r_dirty           <= 1'b1;
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] w_zero, w_lz;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_zero
    assign w_zero[i] = (r_disp[i] == 4'd0);
  end

  // A digit is suppressed when it and every more significant digit is zero.
  assign w_lz[0] = 1'b0;
  for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_lz
    assign w_lz[i] = &w_zero[NUM_DIGITS-1:i];
  end

  assign w_seg = w_lz[r_idx] ? 7'h00 : f_decode(r_disp[r_idx]);
`else
  assign w_seg = f_decode(r_disp[r_idx]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= '0;
      r_dig_en     <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      if (ena && r_state == ST_SHOW) begin
        r_seg    <= w_seg;
        r_dig_en <= c_one << r_idx;
      end else begin
        r_seg    <= '0;
        r_dig_en <= '0;
      end
      r_frame_tick <= ena && w_frame_end;
    end
  end

  assign seg        = r_seg;
  assign dig_en     = r_dig_en;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-segment BCD 7-segment display. Up to NUM_DIGITS BCD digit values share one segment bus and one 7-segment decode. The block holds the digit values and sequences digit enables with a blanking guard between slots. A valid/ready write port updates the values, and updates become visible only at frame boundaries, so a frame never shows a mix of old and new values. It sits between the user-interface input logic and the top-level output pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
PRESCALE, 1000, clock cycles per digit slot; must be greater than BLANK_CYCLES.
BLANK_CYCLES, 16, cycles at the start of each slot with all digits off (anti-ghosting); must be at least 1.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
ena  in  1  scan enable; low forces the IDLE state.
wr_valid  in  1  write request.
wr_ready  out  1  write accept; a write transfers when wr_valid and wr_ready are both high.
wr_addr  in  $clog2(NUM_DIGITS)  target digit index; 0 is the least significant digit.
wr_data  in  4  BCD value.
seg  out  7  segments a..g on bits 6..0, active high.
dig_en  out  NUM_DIGITS  one-hot digit enable, active high.
frame_tick  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset values:
  - seg=0, dig_en=0, frame_tick=0, wr_ready=1.
  - Slot counter cnt=0, digit index idx=0, state IDLE.
  - Shadow and display banks: every digit =4'hF, which decodes to blank.
- States:
  - IDLE: entered while ena=0.
  - BLANK: cnt < BLANK_CYCLES.
  - SHOW: BLANK_CYCLES <= cnt <= PRESCALE-1.
- Transitions:
  - IDLE -> BLANK on ena=1, with cnt=0 and idx=0.
  - Each cycle, cnt increments. At cnt=PRESCALE-1: cnt returns to 0 and idx increments, wrapping NUM_DIGITS-1 -> 0.
  - ena=0 in any state returns to IDLE next cycle, with cnt=0 and idx=0. There is no partial-slot resume.
- Outputs (all registered, one cycle of latency from cnt/idx/state):
  - IDLE and BLANK: dig_en=0, seg=0.
  - SHOW: dig_en=1<<idx, seg=decode(display[idx]).
  - frame_tick=1 for exactly one cycle, registered from the cycle where cnt=PRESCALE-1 and idx=NUM_DIGITS-1.
- Decode table:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B (hex, bit6=a).
  - Values 10..15 decode to 00 (blank).
- Writes:
  - An accepted write stores wr_data into shadow[wr_addr] and sets a dirty flag.
  - wr_addr >= NUM_DIGITS: the write is accepted and dropped; no state changes.
  - Several writes to the same address before a commit: the last one wins.
- Commit (shadow copied to display, dirty cleared):
  - Occurs in the cycle where cnt=PRESCALE-1 and idx=NUM_DIGITS-1, only when dirty=1.
  - In IDLE, commit occurs every cycle when dirty=1.
  - wr_ready=0 during any commit cycle; a write presented then stalls one cycle.
  - Simultaneous write and commit is impossible by construction.
- Reset mid-scan: all outputs go low immediately (asynchronous) and all data returns to 4'hF.

Optional Feature:
SEG_LZ_BLANK_EN (leading-zero blanking)
- Defined: starting from digit NUM_DIGITS-1 downward, each digit whose display value is 0 shows seg=0, up to the first nonzero digit. Digit 0 is never suppressed. dig_en timing is unchanged.
- Undefined: every digit decodes normally. No leading-zero logic is present.

Test Plan:
All scenarios use NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
1. Reset, then ena=1 with no writes -> dig_en cycles 0001,0010,0100,1000 with 2 blank cycles and 6 on cycles per slot; seg=00 throughout; frame_tick every 32 cycles.
2. Write digits 3,2,1,0 = 1,2,3,4 while in IDLE, then ena=1 -> SHOW slots give dig_en 0001/seg 33, 0010/seg 79, 0100/seg 6D, 1000/seg 30.
3. Mid-frame, write digit0=8 -> the current frame keeps the old value. wr_ready=0 in the commit cycle. seg=7F for digit 0 starting in the next frame.
4. Hold wr_valid across the commit cycle -> exactly one transfer, one cycle late; no lost or duplicate write. Also write wr_addr=7 with NUM_DIGITS=4 overridden to 6 -> dropped.
5. Drop ena mid-SHOW of digit 2 -> next cycle dig_en=0, seg=0. Restore ena -> scan restarts at digit 0 with a blank slot. Assert rst_n=0 mid-slot -> outputs 0 asynchronously.
6. With SEG_LZ_BLANK_EN, display 0,0,4,0 (digit 3..0) -> digits 3 and 2 are blank, digit 1 shows seg=33, digit 0 shows seg=7E. Display 0,0,0,0 -> only digit 0 shows 7E.
